// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants, FSM state type and port-index helper for the two-requester
// on-chip memory arbiter.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr_select2.sv
// Purpose: two-way round-robin pick; pointer breaks ties, a lone requester always wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_select2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner
);

  assign winner = (&req) ? ptr : req[1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Purpose: shares one single-port synchronous memory between requesters m0 and m1.
// Latency: one arbitration cycle, then accept; read data one cycle after acceptance.
// Backpressure: waitrequest is low only in the winner's acceptance cycle.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  arb_state_t        state;
  logic              winner;
  logic              ptr;
  logic              rr_winner;
  logic [1:0]        req;
  logic [1:0]        grant_q;
  logic [1:0]        rvalid_q;
  logic              w_read;
  logic              w_write;
  logic [ADDR_W-1:0] w_address;
  logic [BE_W-1:0]   w_byteenable;
  logic [DATA_W-1:0] w_writedata;
  logic              issue;
  logic              accept;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_select2 u_rr_select2 (
    .req    (req),
    .ptr    (ptr),
    .winner (rr_winner)
  );

  // The winner's command is taken live in the acceptance cycle, so a requester
  // that withdraws before being accepted cancels cleanly.
  always_comb begin
    if (winner) begin
      w_read       = m1_read;
      w_write      = m1_write;
      w_address    = m1_address;
      w_byteenable = m1_byteenable;
      w_writedata  = m1_writedata;
    end else begin
      w_read       = m0_read;
      w_write      = m0_write;
      w_address    = m0_address;
      w_byteenable = m0_byteenable;
      w_writedata  = m0_writedata;
    end
  end

  assign issue  = ~reset & (|grant_q);
  assign accept = issue & (w_read | w_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      winner   <= 1'b0;
      grant_q  <= 2'b00;
      rvalid_q <= 2'b00;
    end else begin
      grant_q  <= 2'b00;
      rvalid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            winner  <= rr_winner;
            grant_q <= port_onehot(rr_winner);
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_read | w_write) begin
            ptr <= ~winner;
            if (w_write) begin
              state <= IDLE;
            end else begin
              rvalid_q <= port_onehot(winner);
              state    <= RDATA;
            end
          end else begin
            state <= IDLE;
          end
        end
        RDATA:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the requester-facing flags combinationally so an in-flight
  // grant or read return is suppressed from the first reset cycle.
  assign m0_waitrequest   = reset | ~grant_q[0];
  assign m1_waitrequest   = reset | ~grant_q[1];
  assign m0_readdatavalid = ~reset & rvalid_q[0];
  assign m1_readdatavalid = ~reset & rvalid_q[1];
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

  assign mem_chipselect = accept;
  assign mem_write      = accept & w_write;
  assign mem_address    = accept ? w_address    : '0;
  assign mem_byteenable = accept ? w_byteenable : '0;
  assign mem_writedata  = accept ? w_writedata  : '0;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a synchronous RAM behind the memory port, an
// event-scheduled reference model checked every cycle, and directed scenarios.
module tb_onchip_mem_arbiter;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam logic [DW-1:0] INIT_MEM [4] = '{32'h0A0B0C0D, 32'h11223344, 32'h55667788, 32'h99AABBCC};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_load = 1'b1;
  logic [1:0] m_read = 2'b00;
  logic [1:0] m_write = 2'b00;
  logic [AW-1:0] m_addr [2];
  logic [BW-1:0] m_be [2];
  logic [DW-1:0] m_wd [2];

  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  logic [1:0] m_wait, m_rdv;
  logic [DW-1:0] m_rd [2];
  assign m_wait = {m1_waitrequest, m0_waitrequest};
  assign m_rdv  = {m1_readdatavalid, m0_readdatavalid};
  assign m_rd[0] = m0_readdata;
  assign m_rd[1] = m1_readdata;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m_addr[0]), .m0_byteenable(m_be[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_wd[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m_addr[1]), .m1_byteenable(m_be[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_wd[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Memory behind the arbiter: byte-lane writes, registered read data.
  logic [DW-1:0] ram [4];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 4; i++) ram[i] <= INIT_MEM[i];
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int n_checks = 0;
  int n_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: got no response within bound, expected one (cycle %0d)", name, tcyc);
  endtask

  // Reference model: each entry is the cycle at which an event is due.
  logic [DW-1:0] ref_mem [4];
  int arb_at = -1, grant_at = -1, grant_who = 0, data_at = -1, data_who = 0, ptr_m = 0;
  logic [DW-1:0] data_val;
  logic [1:0] e_wait, e_rdv;
  logic [DW-1:0] e_rd [2];
  logic e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_wd;

  initial for (int i = 0; i < 4; i++) ref_mem[i] = INIT_MEM[i];

  always @(negedge clk) begin : model_cmp
    int c, w;
    bit p0, p1;
    c = tcyc;
    e_wait = 2'b11; e_rdv = 2'b00; e_rd[0] = '0; e_rd[1] = '0;
    e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wd = '0;
    if (reset) begin
      arb_at = c + 1; grant_at = -1; data_at = -1; ptr_m = 0;
    end else begin
      if (c == data_at) begin
        e_rdv[data_who] = 1'b1;
        e_rd[data_who] = data_val;
        data_at = -1;
      end
      if (c == grant_at) begin
        w = grant_who;
        e_wait[w] = 1'b0;
        if (m_read[w] || m_write[w]) begin
          e_cs = 1'b1; e_we = m_write[w];
          e_addr = m_addr[w]; e_be = m_be[w]; e_wd = m_wd[w];
          ptr_m = 1 - w;
          if (m_write[w]) begin
            for (int b = 0; b < BW; b++)
              if (m_be[w][b]) ref_mem[m_addr[w]][8*b +: 8] = m_wd[w][8*b +: 8];
            arb_at = c + 1;
          end else begin
            data_val = ref_mem[m_addr[w]];
            data_who = w;
            data_at = c + 1;
            arb_at = c + 2;
          end
        end else begin
          arb_at = c + 1;
        end
        grant_at = -1;
      end
      if (c == arb_at) begin
        p0 = m_read[0] | m_write[0];
        p1 = m_read[1] | m_write[1];
        if (p0 || p1) begin
          grant_who = (p0 && p1) ? ptr_m : (p1 ? 1 : 0);
          grant_at = c + 1;
        end else begin
          arb_at = c + 1;
        end
      end
    end
    chk("waitrequest", 64'(m_wait), 64'(e_wait));
    chk("readdatavalid", 64'(m_rdv), 64'(e_rdv));
    chk("m0_readdata", 64'(m_rd[0]), 64'(e_rd[0]));
    chk("m1_readdata", 64'(m_rd[1]), 64'(e_rd[1]));
    chk("mem_cs_we", 64'({mem_chipselect, mem_write}), 64'({e_cs, e_we}));
    chk("mem_addr_be", 64'({mem_address, mem_byteenable}), 64'({e_addr, e_be}));
    chk("mem_writedata", 64'(mem_writedata), 64'(e_wd));
    chk("mem_clken", 64'(mem_clken), 64'(1));
    chk("rdv_onehot", 64'(m_rdv == 2'b11), 64'(0));
  end

  task automatic idle(input int m);
    m_read[m] = 1'b0;
    m_write[m] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Holds a command until accepted; returns one step after the acceptance edge.
  task automatic do_cmd(input int m, input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd, output int acc);
    m_write[m] = wr; m_read[m] = rd; m_addr[m] = a; m_be[m] = be; m_wd[m] = wd;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!m_wait[m]) begin
        acc = tcyc;
        break;
      end
    end
    if (acc < 0) fail_now("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdv(input int m, output logic [DW-1:0] d, output int rc);
    rc = -1;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_rdv[m]) begin
        rc = tcyc;
        d = m_rd[m];
        break;
      end
    end
    if (rc < 0) fail_now("rdv_timeout");
    @(posedge clk);
    #1;
  endtask

  int who_q[$];
  int acc_q[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int a0, a1, rc;
    logic [DW-1:0] d;
    bit [1:0] r;
    bit got;
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_be[m] = '0; m_wd[m] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ram_load = 1'b0;

    // Full-word write then read-back by m0.
    do_cmd(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'hDEADBEEF, a0);
    do_cmd(0, 1'b0, 1'b1, 2'd2, 4'hF, 32'h0, a1);
    idle(0);
    wait_rdv(0, d, rc);
    chk("t1_write_to_read_spacing", 64'(a1 - a0), 64'(2));
    chk("t1_read_data", 64'(d), 64'(32'hDEADBEEF));
    chk("t1_read_latency", 64'(rc - a1), 64'(1));

    // Partial write through lanes 0 and 2 by m1.
    do_cmd(1, 1'b1, 1'b0, 2'd1, 4'h5, 32'hAABBCCDD, a0);
    do_cmd(1, 1'b0, 1'b1, 2'd1, 4'hF, 32'h0, a1);
    idle(1);
    wait_rdv(1, d, rc);
    chk("t2_read_data", 64'(d), 64'(32'h11BB33DD));
    chk("t2_read_latency", 64'(rc - a1), 64'(1));

    // Continuous contention from both sides must alternate starting with m0.
    do_reset();
    fork
      begin
        int x0;
        for (int i = 0; i < 3; i++) begin
          do_cmd(0, 1'b0, 1'b1, 2'(i), 4'hF, 32'h0, x0);
          who_q.push_back(0);
          acc_q.push_back(x0);
        end
        idle(0);
      end
      begin
        int x1;
        for (int i = 0; i < 3; i++) begin
          do_cmd(1, 1'b0, 1'b1, 2'(3 - i), 4'hF, 32'h0, x1);
          who_q.push_back(1);
          acc_q.push_back(x1);
        end
        idle(1);
      end
    join
    chk("t3_grant_count", 64'(who_q.size()), 64'(6));
    for (int k = 0; k < who_q.size(); k++) begin
      chk($sformatf("t3_grant_order_%0d", k), 64'(who_q[k]), 64'(k % 2));
      if (k > 0) chk($sformatf("t3_grant_spacing_%0d", k), 64'(acc_q[k] - acc_q[k-1]), 64'(3));
    end

    // m0 withdraws during its acceptance cycle; priority must stay with m0.
    do_reset();
    m_read[0] = 1'b1;
    m_addr[0] = 2'd0;
    @(posedge clk);
    #1 m_read[0] = 1'b0;
    @(negedge clk);
    chk("t4_cancel_chipselect", 64'(mem_chipselect), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_cancel_no_rdv", 64'(m_rdv), 64'(0));
    end
    @(posedge clk);
    #1;
    m_read = 2'b11;
    m_addr[0] = 2'd1;
    m_addr[1] = 2'd2;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_wait != 2'b11) begin
        chk("t4_priority_after_cancel", 64'(m_wait), 64'(2'b10));
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("t4_priority_timeout");
    @(posedge clk);
    #1 m_read = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    // Reset lands in the read-return cycle; the return is suppressed.
    do_cmd(0, 1'b0, 1'b1, 2'd3, 4'hF, 32'h0, a0);
    reset = 1'b1;
    idle(0);
    @(negedge clk);
    chk("t5_rdv_during_reset", 64'(m_rdv), 64'(0));
    chk("t5_wait_during_reset", 64'(m_wait), 64'(2'b11));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_reset", 64'(m_wait), 64'(2'b11));
    @(posedge clk);
    #1;
    do_cmd(1, 1'b0, 1'b1, 2'd2, 4'hF, 32'h0, a1);
    idle(1);
    wait_rdv(1, d, rc);
    chk("t5_read_data", 64'(d), 64'(32'hDEADBEEF));
    chk("t5_read_latency", 64'(rc - a1), 64'(1));

    // Mixed traffic, including withdrawals, checked by the per-cycle model.
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = 2'($urandom_range(0, 3));
          m_read[m] = r[0];
          m_write[m] = r[1];
          m_addr[m] = 2'($urandom_range(0, 3));
          m_be[m] = 4'($urandom_range(0, 15));
          m_wd[m] = $urandom;
        end
      end
    end
    idle(0);
    idle(1);
    repeat (6) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
